// File: rtl/rotary_led_ctrl.sv
// Quadrature rotary encoder front end driving an N_LEDS position indicator.
// Define ROTARY_LED_BAR_EN for thermometer (bar graph) LEDs instead of one-hot.
module rotary_led_ctrl #(
    parameter int N_LEDS     = 8,
    parameter int DEB_CYCLES = 4,
    parameter bit WRAP       = 1'b1,
    parameter int INIT_POS   = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ROT_A,
    input  logic                      ROT_B,
    output logic [N_LEDS-1:0]         led,
    output logic [$clog2(N_LEDS)-1:0] pos,
    output logic                      step_valid,
    output logic                      step_dir
);
    localparam int            PW       = $clog2(N_LEDS);
    localparam logic [7:0]    DEB_LAST = 8'(DEB_CYCLES - 1);
    localparam logic [PW-1:0] POS_MAX  = PW'(N_LEDS - 1);
    localparam logic [PW-1:0] POS_INIT = PW'(INIT_POS);

    function automatic logic [N_LEDS-1:0] encode_led(input logic [PW-1:0] p);
        logic [N_LEDS-1:0] r;
        r = {N_LEDS{1'b0}};
        for (int i = 0; i < N_LEDS; i++) begin
`ifdef ROTARY_LED_BAR_EN
            r[i] = (PW'(i) <= p);
`else
            r[i] = (PW'(i) == p);
`endif
        end
        return r;
    endfunction

    function automatic logic [PW-1:0] step_pos(input logic [PW-1:0] p, input logic up);
        logic [PW-1:0] r;
        if (up) begin
            if (p == POS_MAX) begin
                r = WRAP ? {PW{1'b0}} : POS_MAX;
            end else begin
                r = p + PW'(1'b1);
            end
        end else begin
            if (p == {PW{1'b0}}) begin
                r = WRAP ? POS_MAX : {PW{1'b0}};
            end else begin
                r = p - PW'(1'b1);
            end
        end
        return r;
    endfunction

    // Returns {next filtered level, next count}; an agreeing sample restarts the count.
    function automatic logic [8:0] deb_next(input logic lvl, input logic smp, input logic [7:0] cnt);
        logic [8:0] r;
        if (smp == lvl) begin
            r = {lvl, 8'd0};
        end else if (cnt == DEB_LAST) begin
            r = {smp, 8'd0};
        end else begin
            r = {lvl, cnt + 8'd1};
        end
        return r;
    endfunction

    logic [1:0]        sync1_r;
    logic [1:0]        sync2_r;
    logic              filt_a_r;
    logic              filt_b_r;
    logic [7:0]        cnt_a_r;
    logic [7:0]        cnt_b_r;
    logic [8:0]        deb_a_s;
    logic [8:0]        deb_b_s;
    logic              ev_r;
    logic              ev_d_r;
    logic              dir_r;
    logic              step_valid_r;
    logic              step_dir_r;
    logic [PW-1:0]     pos_r;
    logic [PW-1:0]     pos_nx_s;
    logic [N_LEDS-1:0] led_r;

    // Next-state for both debounce filters and the stepped position.
    always_comb begin
        deb_a_s  = deb_next(filt_a_r, sync2_r[0], cnt_a_r);
        deb_b_s  = deb_next(filt_b_r, sync2_r[1], cnt_b_r);
        pos_nx_s = step_pos(pos_r, step_dir_r);
    end

    // Two-flop synchronisers (bit 0 = A, bit 1 = B) and debounce state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r  <= 2'b00;
            sync2_r  <= 2'b00;
            filt_a_r <= 1'b0;
            filt_b_r <= 1'b0;
            cnt_a_r  <= 8'd0;
            cnt_b_r  <= 8'd0;
        end else begin
            sync1_r  <= {ROT_B, ROT_A};
            sync2_r  <= sync1_r;
            filt_a_r <= deb_a_s[8];
            cnt_a_r  <= deb_a_s[7:0];
            filt_b_r <= deb_b_s[8];
            cnt_b_r  <= deb_b_s[7:0];
        end
    end

    // Quadrature decode: ev marks the 11 detent, dir remembers which channel led.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ev_r         <= 1'b0;
            ev_d_r       <= 1'b0;
            dir_r        <= 1'b0;
            step_valid_r <= 1'b0;
            step_dir_r   <= 1'b0;
        end else begin
            case ({filt_a_r, filt_b_r})
                2'b11: begin
                    ev_r  <= 1'b1;
                    dir_r <= dir_r;
                end
                2'b00: begin
                    ev_r  <= 1'b0;
                    dir_r <= dir_r;
                end
                2'b10: begin
                    ev_r  <= ev_r;
                    dir_r <= 1'b0;
                end
                2'b01: begin
                    ev_r  <= ev_r;
                    dir_r <= 1'b1;
                end
                default: begin
                    ev_r  <= ev_r;
                    dir_r <= dir_r;
                end
            endcase
            ev_d_r       <= ev_r;
            step_valid_r <= ev_r & ~ev_d_r;
            if (ev_r & ~ev_d_r) begin
                step_dir_r <= ~dir_r;
            end else begin
                step_dir_r <= step_dir_r;
            end
        end
    end

    // Position and LED pattern move at the edge that closes the step pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pos_r <= POS_INIT;
            led_r <= encode_led(POS_INIT);
        end else if (step_valid_r) begin
            pos_r <= pos_nx_s;
            led_r <= encode_led(pos_nx_s);
        end else begin
            pos_r <= pos_r;
            led_r <= led_r;
        end
    end

    assign led        = led_r;
    assign pos        = pos_r;
    assign step_valid = step_valid_r;
    assign step_dir   = step_dir_r;

endmodule

// File: doc/rotary_led_ctrl.md
ROTARY_LED_CTRL -- requirements
Module: rotary_led_ctrl

Interface
REQ-001 Parameter N_LEDS, default 8, legal 2..32: number of LED outputs and position count.
REQ-002 Parameter DEB_CYCLES, default 4, legal 1..255: consecutive stable samples needed to accept a new ROT_A/ROT_B level.
REQ-003 Parameter WRAP, default 1: 1 = position wraps at the ends, 0 = position saturates at the ends.
REQ-004 Parameter INIT_POS, default 0, legal 0..N_LEDS-1: position loaded at reset.
REQ-005 Port clk, input, 1: single clock, all state changes on rising edge.
REQ-006 Port rst_n, input, 1: reset, synchronous, active-low.
REQ-007 Port ROT_A, input, 1: encoder channel A, asynchronous to clk.
REQ-008 Port ROT_B, input, 1: encoder channel B, asynchronous to clk.
REQ-009 Port led, output, N_LEDS: LED drive, registered.
REQ-010 Port pos, output, clog2(N_LEDS): current position, registered.
REQ-011 Port step_valid, output, 1: one-cycle pulse per accepted detent, registered.
REQ-012 Port step_dir, output, 1: direction of the step, 1 = clockwise (increment), 0 = anticlockwise; meaningful only while step_valid=1.

Function
REQ-013 ROT_A and ROT_B each pass through a two-flop synchroniser before any other logic.
REQ-014 Each synchronised channel has its own debounce filter: filtered level takes the synchronised value only after DEB_CYCLES consecutive cycles differing from the current filtered level; any agreeing sample clears the count.
REQ-015 Event flag ev: set when filtered A=1 and B=1; cleared when A=0 and B=0; held otherwise.
REQ-016 Direction flag dir: set to 0 when filtered A=1,B=0; set to 1 when A=0,B=1; held otherwise.
REQ-017 A step occurs on each 0->1 transition of ev; step_dir = NOT dir at that transition; 1->0 transitions of ev produce no step.
REQ-018 Latency: counting as edge 1 the first rising edge sampling a final, stable input level that completes A=B=1, step_valid is high for the cycle after edge DEB_CYCLES+4 and for exactly one cycle.
REQ-019 pos and led update at the edge ending the step_valid cycle; pos +1 for step_dir=1, -1 for step_dir=0.
REQ-020 WRAP=1: N_LEDS-1 +1 -> 0; 0 -1 -> N_LEDS-1.
REQ-021 WRAP=0: N_LEDS-1 +1 stays N_LEDS-1; 0 -1 stays 0; step_valid still pulses at a saturated end.
REQ-022 Default led encoding is one-hot: led[i]=1 iff i=pos.
REQ-023 Input glitches shorter than DEB_CYCLES cycles after synchronisation produce no step and no change to ev, dir, pos or led.
REQ-024 Both channels changing in the same cycle is processed through the same filters; at most one step per ev rising edge.

Reset
REQ-025 While rst_n=0 at a rising edge: synchroniser flops, filtered levels and ev clear to 0, debounce counts to 0, dir to 0, pos to INIT_POS, led to the encoding of INIT_POS, step_valid to 0.
REQ-026 Reset asserted mid-debounce or on the step_valid cycle discards the pending step; pos is INIT_POS on the first cycle after release.
REQ-027 No step is generated during the first DEB_CYCLES+4 cycles after reset release even if ROT_A=ROT_B=1 is held (filtered levels start at 0, so one step may then follow per REQ-017).

Configuration
REQ-028 Macro ROTARY_LED_BAR_EN defined: led uses thermometer encoding, led[i]=1 iff i<=pos; undefined: one-hot per REQ-022; all other behaviour identical.

Verification
REQ-029 N_LEDS=8, DEB_CYCLES=4, INIT_POS=0: one clockwise quadrature cycle (A rises before B, detents 20 cycles apart) -> one step_valid, step_dir=1, pos=1, led=8'b0000_0010.
REQ-030 Same config, 9 anticlockwise detents from pos 0, WRAP=1 -> pos sequence 7,6,...,0,7, final led=8'b1000_0000.
REQ-031 WRAP=0, pos 7, 3 clockwise detents -> 3 step_valid pulses, pos stays 7.
REQ-032 DEB_CYCLES=4: 3-cycle pulses on ROT_A with ROT_B=1 -> no step_valid, pos unchanged; 5-cycle stable level -> step at exactly edge DEB_CYCLES+4 per REQ-018.
REQ-033 Drive rst_n=0 for one cycle during the step_valid cycle at pos 3, INIT_POS=2 -> pos=2, led=8'b0000_0100, no further step.
REQ-034 With ROTARY_LED_BAR_EN, N_LEDS=8, pos driven to 3 -> led=8'b0000_1111.
